// File: rtl/fp_sub_and_compare.sv
// Digit-serial multi-precision subtractor r = a + ~b + carry_in, LSB digit first,
// with a running magnitude compare of the result against COMPARE_CONST.
module fp_sub_and_compare #(
  parameter int unsigned               RADIX         = 32,
  parameter int unsigned               DIGITS        = 14,
  parameter logic [RADIX*DIGITS-1:0]   COMPARE_CONST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             carry_in,
  input  logic             digit_in_valid,
  input  logic [RADIX-1:0] digit_a,
  input  logic [RADIX-1:0] digit_b,
  output logic             digit_out_valid,
  output logic [RADIX-1:0] digit_res,
  output logic             a_minus_b_bigger_than_const,
  output logic             done,
  output logic             carry_out
);

  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               gt_q, gt_d;
  logic [RADIX-1:0]   res_q, res_d;
  logic               dov_q, dov_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
  logic               flag_q, flag_d;

  logic [RADIX:0]     sum;
  logic [RADIX-1:0]   cdig;
  logic               gt_next;

  function automatic logic [RADIX-1:0] const_digit(input logic [CNT_W-1:0] k);
    logic [RADIX*DIGITS-1:0] sh;
    sh = COMPARE_CONST >> (32'(k) * RADIX);
    return sh[RADIX-1:0];
  endfunction

  always_comb begin
    sum     = {1'b0, digit_a} + {1'b0, ~digit_b} + {{RADIX{1'b0}}, carry_q};
    cdig    = const_digit(cnt_q);
    // Later (more significant) digits override the verdict of earlier ones.
    gt_next = gt_q;
    if (sum[RADIX-1:0] > cdig)      gt_next = 1'b1;
    else if (sum[RADIX-1:0] < cdig) gt_next = 1'b0;

    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    gt_d    = gt_q;
    res_d   = res_q;
    dov_d   = 1'b0;
    done_d  = 1'b0;
    cout_d  = cout_q;
    flag_d  = flag_q;

    if (start) begin
      state_d = BUSY;
      cnt_d   = '0;
      carry_d = carry_in;
      gt_d    = 1'b0;
      cout_d  = 1'b0;
      flag_d  = 1'b0;
    end else if (state_q == BUSY && digit_in_valid) begin
      res_d   = sum[RADIX-1:0];
      carry_d = sum[RADIX];
      gt_d    = gt_next;
      dov_d   = 1'b1;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DIGITS - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        cout_d  = sum[RADIX];
        flag_d  = sum[RADIX] & gt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      gt_q    <= 1'b0;
      res_q   <= '0;
      dov_q   <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      gt_q    <= gt_d;
      res_q   <= res_d;
      dov_q   <= dov_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      flag_q  <= flag_d;
    end
  end

  assign digit_out_valid             = dov_q;
  assign digit_res                   = res_q;
  assign done                        = done_q;
  assign carry_out                   = cout_q;
  assign a_minus_b_bigger_than_const = flag_q;

endmodule

// File: tb/tb_fp_sub_and_compare.sv
// Bench for fp_sub_and_compare: directed and random operands against a
// whole-operand arithmetic reference of a + ~b + carry_in.
module tb_fp_sub_and_compare;

  localparam int unsigned RADIX  = 32;
  localparam int unsigned DIGITS = 14;
  localparam int unsigned W      = RADIX * DIGITS;
  localparam logic [W-1:0] CONST = '0;

  typedef logic [W-1:0] op_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             carry_in = 1'b0;
  logic             digit_in_valid = 1'b0;
  logic [RADIX-1:0] digit_a = '0;
  logic [RADIX-1:0] digit_b = '0;
  logic             digit_out_valid;
  logic [RADIX-1:0] digit_res;
  logic             flag;
  logic             done;
  logic             carry_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [RADIX-1:0] last_res = '0;
  logic             last_cout = 1'b0;
  logic             last_flag = 1'b0;

  fp_sub_and_compare #(.RADIX(RADIX), .DIGITS(DIGITS), .COMPARE_CONST(CONST)) dut (
    .clk(clk), .rst(rst), .start(start), .carry_in(carry_in),
    .digit_in_valid(digit_in_valid), .digit_a(digit_a), .digit_b(digit_b),
    .digit_out_valid(digit_out_valid), .digit_res(digit_res),
    .a_minus_b_bigger_than_const(flag), .done(done), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".dov"},  64'(digit_out_valid), 64'(0));
    check({tag, ".done"}, 64'(done), 64'(0));
    check({tag, ".res"},  64'(digit_res), 64'(last_res));
    check({tag, ".cout"}, 64'(carry_out), 64'(last_cout));
    check({tag, ".flag"}, 64'(flag), 64'(last_flag));
  endtask

  // abort_after >= 0 stops feeding digits after that many, leaving the op unfinished.
  task automatic run_op(input string name, input op_t a, input op_t b, input logic cin,
                        input int gap_min, input int gap_max, input int abort_after);
    logic [W:0] full;
    op_t        r_exp;
    logic       c_exp, f_exp;
    int         gap;
    full  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
    r_exp = full[W-1:0];
    c_exp = full[W];
    f_exp = c_exp & (r_exp > CONST);

    // A digit presented alongside start must be dropped.
    start = 1'b1; carry_in = cin;
    digit_in_valid = 1'b1; digit_a = $urandom; digit_b = $urandom;
    tick();
    start = 1'b0; digit_in_valid = 1'b0;
    last_cout = 1'b0; last_flag = 1'b0;
    check_quiet({name, ".start"});

    for (int k = 0; k < int'(DIGITS); k++) begin
      if (abort_after >= 0 && k == abort_after) return;
      digit_in_valid = 1'b1;
      digit_a = a[k*RADIX +: RADIX];
      digit_b = b[k*RADIX +: RADIX];
      tick();
      digit_in_valid = 1'b0;
      last_res = r_exp[k*RADIX +: RADIX];
      check({name, ".dov"},  64'(digit_out_valid), 64'(1));
      check({name, ".res"},  64'(digit_res), 64'(last_res));
      check({name, ".done"}, 64'(done), 64'(k == int'(DIGITS) - 1));
      if (k == int'(DIGITS) - 1) begin
        last_cout = c_exp; last_flag = f_exp;
        check({name, ".cout"}, 64'(carry_out), 64'(c_exp));
        check({name, ".flag"}, 64'(flag), 64'(f_exp));
      end
      gap = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_quiet({name, ".gap"});
      end
    end

    // Digits offered after completion produce nothing.
    digit_in_valid = 1'b1; digit_a = $urandom; digit_b = $urandom;
    tick();
    tick();
    digit_in_valid = 1'b0;
    check_quiet({name, ".idle"});
  endtask

  initial begin
    op_t a, b;

    repeat (2) tick();
    last_res = '0; last_cout = 1'b0; last_flag = 1'b0;
    check_quiet("reset");
    rst = 1'b0;
    digit_in_valid = 1'b1; digit_a = 32'h5; digit_b = 32'h3;
    tick();
    digit_in_valid = 1'b0;
    check_quiet("idle_before_start");

    run_op("a5_b3", op_t'(5), op_t'(3), 1'b1, 0, 0, -1);

    for (int i = 0; i < int'(DIGITS); i++) a[i*RADIX +: RADIX] = $urandom;
    run_op("a_eq_b", a, a, 1'b1, 0, 0, -1);

    run_op("a3_b5", op_t'(3), op_t'(5), 1'b1, 0, 0, -1);
    run_op("borrow_gap2", op_t'(64'h1_0000_0000), op_t'(1), 1'b1, 2, 2, -1);
    run_op("cin0_eq7", op_t'(7), op_t'(7), 1'b0, 0, 0, -1);

    // Abort by a fresh start after 5 digits.
    for (int i = 0; i < int'(DIGITS); i++) begin
      a[i*RADIX +: RADIX] = $urandom; b[i*RADIX +: RADIX] = $urandom;
    end
    run_op("abort_start", a, b, 1'b1, 0, 1, 5);
    run_op("after_abort", b, a, 1'b1, 0, 1, -1);

    // Abort by reset after 5 digits.
    run_op("abort_rst", a, b, 1'b1, 0, 0, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_res = '0; last_cout = 1'b0; last_flag = 1'b0;
    check_quiet("mid_reset");
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit_in_valid = 1'b1; digit_a = $urandom; digit_b = $urandom;
      tick();
      check_quiet("post_reset_idle");
    end
    digit_in_valid = 1'b0;
    run_op("after_rst", a, b, 1'b1, 0, 0, -1);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        a[i*RADIX +: RADIX] = $urandom; b[i*RADIX +: RADIX] = $urandom;
      end
      if (t == 3) b = a;
      if (t == 5) b[W-1 -: RADIX] = a[W-1 -: RADIX];
      run_op("random", a, b, 1'($urandom), 0, 3, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
